// File: rtl/game_flow_pkg.sv
// Shared state encodings, renderer select codes and state classification helpers
// for the game flow controller.
package game_flow_pkg;

  typedef enum logic [3:0] {
    ST_DRAW_START  = 4'd0,
    ST_WAIT_START  = 4'd1,
    ST_ERASE_START = 4'd2,
    ST_DRAW_FRAME  = 4'd3,
    ST_STALL       = 4'd4,
    ST_ERASE_FRAME = 4'd5,
    ST_PROGRESS    = 4'd6,
    ST_DRAW_OVER   = 4'd7,
    ST_WAIT_OVER   = 4'd8
  } state_t;

  localparam logic [2:0] SEL_START       = 3'd0;
  localparam logic [2:0] SEL_ERASE_START = 3'd1;
  localparam logic [2:0] SEL_FRAME       = 3'd2;
  localparam logic [2:0] SEL_ERASE_FRAME = 3'd3;
  localparam logic [2:0] SEL_GAME_OVER   = 3'd4;

  function automatic logic isDrawState(state_t s);
    case (s)
      ST_DRAW_START, ST_ERASE_START, ST_DRAW_FRAME,
      ST_ERASE_FRAME, ST_DRAW_OVER: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  function automatic logic isActiveState(state_t s);
    case (s)
      ST_DRAW_FRAME, ST_STALL, ST_ERASE_FRAME, ST_PROGRESS: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

  // Non-draw states present SEL_START; the renderer ignores draw_sel there.
  function automatic logic [2:0] drawSelOf(state_t s);
    case (s)
      ST_ERASE_START: return SEL_ERASE_START;
      ST_DRAW_FRAME:  return SEL_FRAME;
      ST_ERASE_FRAME: return SEL_ERASE_FRAME;
      ST_DRAW_OVER:   return SEL_GAME_OVER;
      default:        return SEL_START;
    endcase
  endfunction

  function automatic state_t drawNextState(state_t s);
    case (s)
      ST_DRAW_START:  return ST_WAIT_START;
      ST_ERASE_START: return ST_DRAW_FRAME;
      ST_DRAW_FRAME:  return ST_STALL;
      ST_ERASE_FRAME: return ST_PROGRESS;
      ST_DRAW_OVER:   return ST_WAIT_OVER;
      default:        return ST_DRAW_START;
    endcase
  endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Bundles the tick/button/game-logic inputs and renderer/game-logic outputs of the
// game flow controller; master is the controller side.
interface game_flow_ctrl_if #(
  parameter int FRAME_CNT_W = 16
);
  logic                   game_tick_pulse;
  logic                   start_btn;
  logic                   collision;
  logic                   draw_done;
  logic                   draw_req;
  logic [2:0]             draw_sel;
  logic                   advance;
  logic                   game_active;
  logic [FRAME_CNT_W-1:0] frame_count;
  logic                   paused;
  logic [3:0]             state_out;

  modport master (
    input  game_tick_pulse, start_btn, collision, draw_done,
    output draw_req, draw_sel, advance, game_active, frame_count, paused, state_out
  );

  modport slave (
    output game_tick_pulse, start_btn, collision, draw_done,
    input  draw_req, draw_sel, advance, game_active, frame_count, paused, state_out
  );
endinterface

// File: rtl/game_flow_handshake.sv
// Per-state renderer request sequencer: request stays low on the entry cycle of a draw
// state, rises next edge, and is accepted when draw_done is seen while it is high.
module game_flow_handshake (
  input  logic clk,
  input  logic reset,
  input  logic drawState_i,
  input  logic done_i,
  output logic req_o,
  output logic accept_o
);

  logic req_q, req_d;

  // req_q can only be high if the previous cycle was this same draw state, so an
  // accept always belongs to the current state and forces a low cycle afterwards.
  assign accept_o = req_q & done_i;
  assign req_d    = drawState_i & ~accept_o;
  assign req_o    = req_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) req_q <= 1'b0;
    else       req_q <= req_d;
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game flow controller: start screen, gameplay frames and game-over screen with a renderer
// handshake. Define GAME_FLOW_PAUSE_EN to let a start edge in STALL pause/resume ticking.
module game_flow_ctrl #(
  parameter int TICKS_PER_FRAME = 1,
  parameter int TICK_CNT_W      = 4,
  parameter int FRAME_CNT_W     = 16
) (
  input logic              clk,
  input logic              reset,
  game_flow_ctrl_if.master bus
);
  import game_flow_pkg::*;

  localparam logic [TICK_CNT_W-1:0] LAST_TICK = TICK_CNT_W'(TICKS_PER_FRAME - 1);

  state_t                 state_q, state_d;
  logic [TICK_CNT_W-1:0]  tickCnt_q, tickCnt_d;
  logic [FRAME_CNT_W-1:0] frameCnt_q, frameCnt_d;
  logic                   startPrev_q;
  logic                   startEdge, pausedNow, tickTaken, finalTick, enterStall;
  logic                   drawReq, drawAccept;

  assign startEdge  = bus.start_btn & ~startPrev_q;
  assign tickTaken  = (state_q == ST_STALL) & bus.game_tick_pulse & ~pausedNow;
  assign finalTick  = tickTaken & (tickCnt_q == LAST_TICK);
  assign enterStall = (state_q != ST_STALL) & (state_d == ST_STALL);

  game_flow_handshake u_handshake (
    .clk        (clk),
    .reset      (reset),
    .drawState_i(isDrawState(state_q)),
    .done_i     (bus.draw_done),
    .req_o      (drawReq),
    .accept_o   (drawAccept)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DRAW_START, ST_ERASE_START, ST_DRAW_FRAME, ST_ERASE_FRAME, ST_DRAW_OVER:
        if (drawAccept) state_d = drawNextState(state_q);
      ST_WAIT_START: if (startEdge) state_d = ST_ERASE_START;
      ST_STALL:      if (finalTick) state_d = ST_ERASE_FRAME;
      ST_PROGRESS:   state_d = bus.collision ? ST_DRAW_OVER : ST_DRAW_FRAME;
      ST_WAIT_OVER:  if (startEdge) state_d = ST_DRAW_START;
      default:       state_d = ST_DRAW_START;
    endcase
  end

  // Frame count restarts on the erase of the start screen so the game-over screen
  // still shows the score of the game just finished.
  always_comb begin
    tickCnt_d  = tickCnt_q;
    frameCnt_d = frameCnt_q;
    if (enterStall)     tickCnt_d = '0;
    else if (tickTaken) tickCnt_d = tickCnt_q + TICK_CNT_W'(1);
    if (state_q == ST_ERASE_START)
      frameCnt_d = '0;
    else if (state_q == ST_PROGRESS && frameCnt_q != '1)
      frameCnt_d = frameCnt_q + FRAME_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_DRAW_START;
      tickCnt_q   <= '0;
      frameCnt_q  <= '0;
      startPrev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tickCnt_q   <= tickCnt_d;
      frameCnt_q  <= frameCnt_d;
      startPrev_q <= bus.start_btn;
    end
  end

`ifdef GAME_FLOW_PAUSE_EN
  logic paused_q, paused_d;

  always_comb begin
    paused_d = paused_q;
    if (state_q != ST_STALL || state_d != ST_STALL) paused_d = 1'b0;
    else if (startEdge)                            paused_d = ~paused_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) paused_q <= 1'b0;
    else       paused_q <= paused_d;
  end

  assign pausedNow = paused_q;
`else
  assign pausedNow = 1'b0;
`endif

  assign bus.draw_req    = drawReq;
  assign bus.draw_sel    = drawSelOf(state_q);
  assign bus.advance     = (state_q == ST_PROGRESS);
  assign bus.game_active = isActiveState(state_q);
  assign bus.frame_count = frameCnt_q;
  assign bus.paused      = pausedNow;
  assign bus.state_out   = state_q;

endmodule
